writeback_unit: RTL and testbench



---
 rtl/writeback_unit.sv | 62 ++++++
 tb/tb_writeback_unit.sv | 134 +++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// writeback_unit: commits decoder results to A/D/PC, issues stalled data-memory writes, counts retirements.
module writeback_unit #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic              imm,
  input  logic [DATA_W-1:0] out,
  input  logic [2:0]        dst,
  input  logic              jmp,
  output logic [DATA_W-1:0] a_reg,
  output logic [DATA_W-1:0] d_reg,
  output logic [DATA_W-1:0] pc,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  retired
);
  typedef enum logic {READY, MEM_WAIT} state_t;
  state_t state, state_n;
  logic accept, wr_mem;
  assign accept      = (state == READY) && instr_valid;
  assign wr_mem      = !imm && dst[0];
  assign instr_ready = (state == READY);
  always_comb begin
    state_n = state;
    state_n = (state == READY) ? ((accept && wr_mem) ? MEM_WAIT : READY)
                               : (mem_ack ? READY : MEM_WAIT);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= READY;
      a_reg     <= '0;
      d_reg     <= '0;
      pc        <= '0;
      retired   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_n;
      if (accept) begin
        a_reg   <= (imm || dst[2]) ? out : a_reg;
        d_reg   <= (!imm && dst[1]) ? out : d_reg;
        // jump target is the pre-edge A even when A is rewritten on this edge
        pc      <= (!imm && jmp) ? a_reg : pc + DATA_W'(1);
        retired <= retired + CNT_W'(1);
        if (wr_mem) begin
          mem_we    <= 1'b1;
          mem_addr  <= a_reg;
          mem_wdata <= out;
        end
      end else if (state == MEM_WAIT && mem_ack) begin
        mem_we <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit: directed stimulus checked every cycle against a behavioural model plus literal pins.
module tb_writeback_unit;
  logic        clk = 0, rst = 0, instr_valid = 0, imm = 0, jmp = 0, mem_ack = 0;
  logic [15:0] out = 0;
  logic [2:0]  dst = 0;
  logic        instr_ready, mem_we;
  logic [15:0] a_reg, d_reg, pc, mem_addr, mem_wdata, retired;
  int pass_cnt = 0, total_cnt = 0;
  logic [15:0] m_a, m_d, m_pc, m_ret, m_addr, m_wdata;
  logic        m_we, m_busy;

  writeback_unit #(.DATA_W(16), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .imm(imm), .out(out), .dst(dst), .jmp(jmp), .a_reg(a_reg), .d_reg(d_reg),
    .pc(pc), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic chk_model();
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, !m_busy});
    chk("a_reg", {16'd0, a_reg}, {16'd0, m_a});
    chk("d_reg", {16'd0, d_reg}, {16'd0, m_d});
    chk("pc", {16'd0, pc}, {16'd0, m_pc});
    chk("retired", {16'd0, retired}, {16'd0, m_ret});
    chk("mem_we", {31'd0, mem_we}, {31'd0, m_we});
    chk("mem_addr", {16'd0, mem_addr}, {16'd0, m_addr});
    chk("mem_wdata", {16'd0, mem_wdata}, {16'd0, m_wdata});
  endtask

  // One clock: drive inputs, advance the model by the architectural rules, compare after the edge.
  task automatic cyc(input logic r, input logic v, input logic i, input logic [15:0] o,
                     input logic [2:0] d, input logic j, input logic ack);
    logic [15:0] old_a;
    rst = r; instr_valid = v; imm = i; out = o; dst = d; jmp = j; mem_ack = ack;
    old_a = m_a;
    if (r) begin
      {m_a, m_d, m_pc, m_ret, m_addr, m_wdata} = '0;
      m_we = 0; m_busy = 0;
    end else if (m_busy) begin
      if (ack) begin m_we = 0; m_busy = 0; end
    end else if (v) begin
      m_ret = m_ret + 16'd1;
      if (i) begin
        m_a = o;
        m_pc = m_pc + 16'd1;
      end else begin
        if (d[2]) m_a = o;
        if (d[1]) m_d = o;
        m_pc = j ? old_a : m_pc + 16'd1;
        if (d[0]) begin m_addr = old_a; m_wdata = o; m_we = 1; m_busy = 1; end
      end
    end
    @(posedge clk);
    #1;
    chk_model();
  endtask

  initial begin
    {m_a, m_d, m_pc, m_ret, m_addr, m_wdata} = '0;
    m_we = 0; m_busy = 0;
    #2;
    cyc(1, 0, 0, 0, 3'b000, 0, 0);
    cyc(1, 0, 0, 0, 3'b000, 0, 0);
    chk("rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("rst_pc", {16'd0, pc}, 32'd0);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    cyc(0, 1, 1, 16'h1234, 3'b111, 1, 0);
    chk("imm_a", {16'd0, a_reg}, 32'h1234);
    chk("imm_pc", {16'd0, pc}, 32'd1);
    chk("imm_ret", {16'd0, retired}, 32'd1);
    chk("imm_ready", {31'd0, instr_ready}, 32'd1);
    for (int k = 0; k < 4; k++) cyc(0, 1, 1, 16'h0010, 3'b000, 0, 0);
    chk("pre_pc", {16'd0, pc}, 32'd5);
    cyc(0, 1, 0, 16'h00AA, 3'b110, 0, 0);
    chk("multi_a", {16'd0, a_reg}, 32'h00AA);
    chk("multi_d", {16'd0, d_reg}, 32'h00AA);
    chk("multi_pc", {16'd0, pc}, 32'd6);
    chk("multi_we", {31'd0, mem_we}, 32'd0);
    cyc(0, 0, 0, 16'hDEAD, 3'b111, 1, 1);
    cyc(0, 1, 1, 16'h0040, 3'b000, 0, 0);
    cyc(0, 1, 0, 16'h0099, 3'b100, 1, 0);
    chk("jmp_pc", {16'd0, pc}, 32'h0040);
    chk("jmp_a", {16'd0, a_reg}, 32'h0099);
    cyc(0, 1, 1, 16'h0200, 3'b000, 0, 0);
    cyc(0, 1, 0, 16'h5555, 3'b101, 0, 0);
    chk("wr_we", {31'd0, mem_we}, 32'd1);
    chk("wr_addr", {16'd0, mem_addr}, 32'h0200);
    chk("wr_data", {16'd0, mem_wdata}, 32'h5555);
    chk("wr_a", {16'd0, a_reg}, 32'h5555);
    chk("wr_ready", {31'd0, instr_ready}, 32'd0);
    for (int k = 0; k < 3; k++) cyc(0, 1, 1, 16'h7777, 3'b000, 0, 0);
    chk("stall_ret", {16'd0, retired}, 32'd10);
    chk("stall_pc", {16'd0, pc}, 32'h0042);
    cyc(0, 1, 1, 16'h7777, 3'b000, 0, 1);
    chk("ack_we", {31'd0, mem_we}, 32'd0);
    chk("ack_ready", {31'd0, instr_ready}, 32'd1);
    chk("ack_ret", {16'd0, retired}, 32'd10);
    cyc(0, 1, 1, 16'hFFFF, 3'b000, 0, 0);
    cyc(0, 1, 0, 16'h1111, 3'b000, 1, 0);
    chk("wrap_pre", {16'd0, pc}, 32'hFFFF);
    cyc(0, 1, 0, 16'h1111, 3'b000, 0, 0);
    chk("wrap_pc", {16'd0, pc}, 32'h0000);
    cyc(0, 1, 0, 16'h0BEE, 3'b011, 0, 0);
    chk("dw_d", {16'd0, d_reg}, 32'h0BEE);
    chk("dw_addr", {16'd0, mem_addr}, 32'hFFFF);
    cyc(0, 0, 0, 0, 3'b000, 0, 1);
    chk("fast_ack_ready", {31'd0, instr_ready}, 32'd1);
    chk("pre_stream_ret", {16'd0, retired}, 32'd14);
    for (int k = 0; k < 65521; k++) cyc(0, 1, 1, 16'(k), 3'b000, 0, 0);
    chk("ret_max", {16'd0, retired}, 32'hFFFF);
    cyc(0, 1, 0, 16'h0001, 3'b000, 0, 0);
    chk("ret_wrap", {16'd0, retired}, 32'd0);
    cyc(0, 1, 1, 16'h0300, 3'b000, 0, 0);
    cyc(0, 1, 0, 16'hABCD, 3'b001, 0, 0);
    chk("mid_we", {31'd0, mem_we}, 32'd1);
    cyc(1, 1, 0, 16'hABCD, 3'b001, 0, 0);
    chk("mid_rst_we", {31'd0, mem_we}, 32'd0);
    chk("mid_rst_ready", {31'd0, instr_ready}, 32'd1);
    chk("mid_rst_a", {16'd0, a_reg}, 32'd0);
    cyc(0, 0, 0, 0, 3'b000, 0, 1);
    chk("late_ack_we", {31'd0, mem_we}, 32'd0);
    chk("late_ack_ret", {16'd0, retired}, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
